ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port IDEXA  input  32  rs operand from ID/EX.
REQ-004 SHALL have port IDEXB  input  32  rt operand from ID/EX.
REQ-005 SHALL have port IDEXIR  input  32  instruction from ID/EX.
REQ-006 SHALL have port EXMEMALUOut  output  32  registered result / address / jump target.
REQ-007 SHALL have port EXMEMB  output  32  registered copy of IDEXB (store data).
REQ-008 SHALL have port EXMEMFlagOut  output  1  registered CDEC flag.
REQ-009 SHALL have port EXMEMIR  output  32  registered instruction.
REQ-010 SHALL have port exStall  output  1  combinational; high = upstream holds ID/EX and PC.

Function
REQ-011 SHALL decode op = IDEXIR[31:26], funct = IDEXIR[5:0], imm = sign-extended IDEXIR[15:0], using team opcode constants ALUop, LW, SW, CDEC, IJMP, no_op (no_op = 32'h00000020).
REQ-012 SHALL, for ALUop, compute in one cycle: funct 0x20 A+B, 0x22 A-B, 0x24 A&B, 0x25 A|B, 0x2A signed A<B ? 1 : 0; other non-MULT funct -> 0.
REQ-013 SHALL, for LW and SW, produce EXMEMALUOut = A + imm, modulo 2^32.
REQ-014 SHALL, for CDEC, produce EXMEMALUOut = A - 1 (wraps 0 -> 32'hFFFFFFFF) and EXMEMFlagOut = 1 iff A - 1 == 0.
REQ-015 SHALL, for IJMP, produce EXMEMALUOut = A.
REQ-016 SHALL drive EXMEMFlagOut = 0 for every op except CDEC; unknown ops give EXMEMALUOut = 0.
REQ-017 SHALL register EXMEMB <= IDEXB and EXMEMIR <= IDEXIR on every non-stalled edge; single-cycle latency.
REQ-018 SHALL implement MULT (ALUop, funct 0x18) as a shift-add FSM with states IDLE, BUSY, DONE.
REQ-019 SHALL, in IDLE with MULT present, capture A and B, clear the 64-bit accumulator and 5-bit counter, and go to BUSY.
REQ-020 SHALL, in BUSY, do one shift-add step per cycle, increment the counter, and go to DONE after step 32 (counter wraps 31 -> 0).
REQ-021 SHALL, in DONE, write EXMEMALUOut = product[31:0] and EXMEMIR = IDEXIR, then return to IDLE; MULT occupies 34 edges.
REQ-022 SHALL drive exStall = 1 when IDEXIR is MULT and state != DONE; otherwise 0.
REQ-023 SHALL load EXMEMIR = no_op, EXMEMALUOut = 0 and EXMEMFlagOut = 0 on each edge where exStall = 1 (bubble into MEM).
REQ-024 SHALL ignore changes on IDEXA/IDEXB while in BUSY and use only the captured operands.

Reset
REQ-025 SHALL, on a rising edge with rst_n = 0, set EXMEMALUOut = 0, EXMEMB = 0, EXMEMFlagOut = 0, EXMEMIR = no_op, FSM = IDLE, counter = 0.
REQ-026 SHALL abort an in-flight MULT on reset, discard the partial product, and drop exStall on the first cycle after reset only if IDEXIR is no longer MULT.
REQ-027 SHALL give reset priority over every other update.

Configuration
REQ-028 SHALL compile the MULT FSM only when macro EX_STAGE_MULT_EN is defined.
REQ-029 SHALL, without EX_STAGE_MULT_EN, treat funct 0x18 as unsupported: EXMEMALUOut = 0, single-cycle, no FSM, exStall tied 0.

Verification
REQ-030 SHALL check ADD: A = 5, B = 7, funct 0x20 -> next edge EXMEMALUOut = 12, EXMEMIR = IDEXIR, flag 0.
REQ-031 SHALL check CDEC: A = 1 -> ALUOut 0, flag 1; A = 0 -> ALUOut 32'hFFFFFFFF, flag 0.
REQ-032 SHALL check SW: A = 32'h100, imm = 16'hFFFC, B = 32'hDEAD -> ALUOut 32'hFC, EXMEMB 32'hDEAD.
REQ-033 SHALL check MULT (macro on): A = 32'h10001, B = 3 -> exStall high for 33 cycles, no_op bubbles, then ALUOut 32'h30003.
REQ-034 SHALL check reset mid-MULT: rst_n = 0 at BUSY count 10 -> outputs reset, FSM IDLE, EXMEMIR = no_op.
REQ-035 SHALL check macro off: MULT funct -> exStall never high, ALUOut 0 after one edge.

Source files
------------

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU / address / CDEC / IJMP, plus an optional
// shift-add MULT FSM that stalls upstream; enabled by defining EX_STAGE_MULT_EN.
module ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] IDEXA,
  input  logic [31:0] IDEXB,
  input  logic [31:0] IDEXIR,
  output logic [31:0] EXMEMALUOut,
  output logic [31:0] EXMEMB,
  output logic        EXMEMFlagOut,
  output logic [31:0] EXMEMIR,
  output logic        exStall
);

  localparam int unsigned W = 32;

  localparam logic [5:0]   ALUOP = 6'h00;
  localparam logic [5:0]   LW    = 6'h23;
  localparam logic [5:0]   SW    = 6'h2B;
  localparam logic [5:0]   CDEC  = 6'h38;
  localparam logic [5:0]   IJMP  = 6'h02;
  localparam logic [W-1:0] NO_OP = 32'h0000_0020;

  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_SLT  = 6'h2A;

  logic [5:0]   op;
  logic [5:0]   funct;
  logic [W-1:0] imm;
  logic [W-1:0] dec_c;
  logic [W-1:0] alu_c;
  logic         flag_c;
  logic [W-1:0] result_c;

  assign op    = IDEXIR[31:26];
  assign funct = IDEXIR[5:0];
  assign imm   = {{16{IDEXIR[15]}}, IDEXIR[15:0]};
  assign dec_c = IDEXA - W'(1);

  // Single-cycle datapath for every op except MULT
  always_comb begin
    alu_c  = '0;
    flag_c = 1'b0;
    case (op)
      ALUOP: begin
        case (funct)
          F_ADD:   alu_c = IDEXA + IDEXB;
          F_SUB:   alu_c = IDEXA - IDEXB;
          F_AND:   alu_c = IDEXA & IDEXB;
          F_OR:    alu_c = IDEXA | IDEXB;
          F_SLT:   alu_c = ($signed(IDEXA) < $signed(IDEXB)) ? W'(1) : W'(0);
          default: alu_c = '0;
        endcase
      end
      LW, SW: alu_c = IDEXA + imm;
      CDEC: begin
        alu_c  = dec_c;
        flag_c = (dec_c == '0);
      end
      IJMP:    alu_c = IDEXA;
      default: alu_c = '0;
    endcase
  end

`ifdef EX_STAGE_MULT_EN
  localparam logic [5:0] F_MULT = 6'h18;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [63:0]   acc, acc_nxt;
  logic [63:0]   mcand, mcand_nxt;
  logic [W-1:0]  mplier, mplier_nxt;
  logic [4:0]    cnt, cnt_nxt;
  logic          is_mult_c;

  assign is_mult_c = (op == ALUOP) && (funct == F_MULT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // One shift-add step per BUSY cycle; the 5-bit counter wraps after step 32
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    cnt_nxt    = cnt;
    case (state)
      IDLE: begin
        if (is_mult_c) begin
          mcand_nxt  = {32'h0, IDEXA};
          mplier_nxt = IDEXB;
          acc_nxt    = '0;
          cnt_nxt    = '0;
          state_nxt  = BUSY;
        end
      end
      BUSY: begin
        if (mplier[0]) acc_nxt = acc + mcand;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + 5'(1);
        if (cnt == 5'd31) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign exStall  = is_mult_c && (state != DONE);
  assign result_c = (state == DONE) ? acc[W-1:0] : alu_c;
`else
  assign exStall  = 1'b0;
  assign result_c = alu_c;
`endif

  // EX/MEM pipeline register; a stall pushes a bubble and holds store data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      EXMEMALUOut  <= '0;
      EXMEMB       <= '0;
      EXMEMFlagOut <= 1'b0;
      EXMEMIR      <= NO_OP;
    end else if (exStall) begin
      EXMEMALUOut  <= '0;
      EXMEMFlagOut <= 1'b0;
      EXMEMIR      <= NO_OP;
    end else begin
      EXMEMALUOut  <= result_c;
      EXMEMB       <= IDEXB;
      EXMEMFlagOut <= flag_c;
      EXMEMIR      <= IDEXIR;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized ops against
// an arithmetic reference model; MULT cases follow EX_STAGE_MULT_EN.
module tb_ex_stage;

  localparam logic [5:0]  OP_ALU  = 6'h00;
  localparam logic [5:0]  OP_LW   = 6'h23;
  localparam logic [5:0]  OP_SW   = 6'h2B;
  localparam logic [5:0]  OP_CDEC = 6'h38;
  localparam logic [5:0]  OP_IJMP = 6'h02;
  localparam logic [31:0] NO_OP   = 32'h0000_0020;

  logic        clk;
  logic        rst_n;
  logic [31:0] IDEXA, IDEXB, IDEXIR;
  logic [31:0] EXMEMALUOut, EXMEMB, EXMEMIR;
  logic        EXMEMFlagOut;
  logic        exStall;

  int checks   = 0;
  int failures = 0;

  ex_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IDEXA        (IDEXA),
    .IDEXB        (IDEXB),
    .IDEXIR       (IDEXIR),
    .EXMEMALUOut  (EXMEMALUOut),
    .EXMEMB       (EXMEMB),
    .EXMEMFlagOut (EXMEMFlagOut),
    .EXMEMIR      (EXMEMIR),
    .exStall      (exStall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: returns {flag, result} straight from the ISA rules
  function automatic logic [32:0] model(input logic [31:0] ir, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] imm, r;
    logic        f;
    imm = {{16{ir[15]}}, ir[15:0]};
    r = 32'h0;
    f = 1'b0;
    if (ir[31:26] == OP_ALU) begin
      if (ir[5:0] == 6'h20) r = a + b;
      else if (ir[5:0] == 6'h22) r = a - b;
      else if (ir[5:0] == 6'h24) r = a & b;
      else if (ir[5:0] == 6'h25) r = a | b;
      else if (ir[5:0] == 6'h2A) r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    end else if (ir[31:26] == OP_LW || ir[31:26] == OP_SW) begin
      r = a + imm;
    end else if (ir[31:26] == OP_CDEC) begin
      r = a - 32'd1;
      f = (a == 32'd1);
    end else if (ir[31:26] == OP_IJMP) begin
      r = a;
    end
    return {f, r};
  endfunction

  task automatic run_one(input string tag, input logic [31:0] ir, input logic [31:0] a,
                         input logic [31:0] b);
    logic [32:0] exp;
    IDEXIR = ir;
    IDEXA  = a;
    IDEXB  = b;
    exp    = model(ir, a, b);
    #1;
    chk({tag, "_stall"}, 32'(exStall), 32'd0);
    tick();
    chk({tag, "_alu"}, EXMEMALUOut, exp[31:0]);
    chk({tag, "_flag"}, 32'(EXMEMFlagOut), 32'(exp[32]));
    chk({tag, "_b"}, EXMEMB, b);
    chk({tag, "_ir"}, EXMEMIR, ir);
  endtask

`ifdef EX_STAGE_MULT_EN
  // Issue a MULT held upstream until the stall drops; returns stall-cycle count
  task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b);
    int n;
    logic [31:0] ir;
    ir = {OP_ALU, 20'h12345, 6'h18};
    IDEXIR = ir;
    IDEXA  = a;
    IDEXB  = b;
    n = 0;
    #1;
    while (exStall && n < 40) begin
      n++;
      tick();
      if (EXMEMIR !== NO_OP || EXMEMALUOut !== 32'h0) begin
        chk({tag, "_bubble_ir"}, EXMEMIR, NO_OP);
        chk({tag, "_bubble_alu"}, EXMEMALUOut, 32'h0);
      end
      if (n == 1) begin
        IDEXA = $urandom;
        IDEXB = $urandom;
      end
      #1;
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'd33);
    tick();
    chk({tag, "_prod"}, EXMEMALUOut, a * b);
    chk({tag, "_ir"}, EXMEMIR, ir);
    chk({tag, "_flag"}, 32'(EXMEMFlagOut), 32'd0);
    IDEXIR = NO_OP;
  endtask
`endif

  initial begin
    logic [31:0] ir, a, b;
    logic [5:0]  op, fn;
    rst_n  = 1'b0;
    IDEXA  = $urandom;
    IDEXB  = $urandom;
    IDEXIR = {OP_ALU, 20'h0, 6'h20};
    tick();
    chk("rst_alu", EXMEMALUOut, 32'h0);
    chk("rst_b", EXMEMB, 32'h0);
    chk("rst_flag", 32'(EXMEMFlagOut), 32'd0);
    chk("rst_ir", EXMEMIR, NO_OP);
    rst_n = 1'b1;

    run_one("add", {OP_ALU, 20'h0, 6'h20}, 32'd5, 32'd7);
    chk("add_val", EXMEMALUOut, 32'd12);
    run_one("cdec1", {OP_CDEC, 26'h0}, 32'd1, 32'h55);
    chk("cdec1_flag_set", 32'(EXMEMFlagOut), 32'd1);
    run_one("cdec0", {OP_CDEC, 26'h0}, 32'd0, 32'h66);
    chk("cdec0_wrap", EXMEMALUOut, 32'hFFFF_FFFF);
    run_one("sw", {OP_SW, 10'h0, 16'hFFFC}, 32'h100, 32'hDEAD);
    chk("sw_addr", EXMEMALUOut, 32'hFC);
    run_one("ijmp", {OP_IJMP, 26'h3}, 32'hCAFE_0000, 32'h1);
    run_one("slt_neg", {OP_ALU, 20'h0, 6'h2A}, 32'hFFFF_FFFF, 32'd1);
    chk("slt_neg_val", EXMEMALUOut, 32'd1);

`ifndef EX_STAGE_MULT_EN
    // MULT funct is just an unsupported ALU function without the FSM
    IDEXIR = {OP_ALU, 20'h0, 6'h18};
    IDEXA  = 32'h10001;
    IDEXB  = 32'd3;
    #1;
    chk("nomult_stall", 32'(exStall), 32'd0);
    tick();
    chk("nomult_alu", EXMEMALUOut, 32'h0);
    chk("nomult_ir", EXMEMIR, {OP_ALU, 20'h0, 6'h18});
    chk("nomult_stall2", 32'(exStall), 32'd0);
`else
    run_mult("mult", 32'h10001, 32'd3);
    run_mult("mult_rand", $urandom, $urandom);

    // Abort at BUSY count 10: capture edge plus ten steps
    IDEXIR = {OP_ALU, 20'h0, 6'h18};
    IDEXA  = 32'd9;
    IDEXB  = 32'd9;
    for (int i = 0; i < 11; i++) tick();
    chk("midrst_stall_before", 32'(exStall), 32'd1);
    rst_n  = 1'b0;
    IDEXIR = NO_OP;
    tick();
    rst_n = 1'b1;
    chk("midrst_alu", EXMEMALUOut, 32'h0);
    chk("midrst_b", EXMEMB, 32'h0);
    chk("midrst_flag", 32'(EXMEMFlagOut), 32'd0);
    chk("midrst_ir", EXMEMIR, NO_OP);
    chk("midrst_stall", 32'(exStall), 32'd0);
    run_mult("mult_after_rst", 32'd7, 32'd6);
`endif

    for (int t = 0; t < 300; t++) begin
      ir = $urandom;
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: op = OP_ALU;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_CDEC;
        4: op = OP_IJMP;
        default: begin
          op = 6'($urandom);
          while (op == OP_ALU || op == OP_LW || op == OP_SW || op == OP_CDEC || op == OP_IJMP)
            op = 6'($urandom);
        end
      endcase
      ir[31:26] = op;
      if (op == OP_ALU) begin
        case ($urandom_range(0, 5))
          0: fn = 6'h20;
          1: fn = 6'h22;
          2: fn = 6'h24;
          3: fn = 6'h25;
          4: fn = 6'h2A;
          default: fn = 6'($urandom);
        endcase
`ifdef EX_STAGE_MULT_EN
        if (fn == 6'h18) fn = 6'h20;
`endif
        ir[5:0] = fn;
      end
      if (op == OP_CDEC && $urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 2));
      if (op == OP_ALU && $urandom_range(0, 3) == 0) b = a;
      run_one("rand", ir, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

endmodule
